// File: rtl/bep_pkg.sv
// bep_pkg: shared constants for the BEP receive front end
// Default parameter values for the input conditioner and the encoding of edge direction.
package bep_pkg;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILTER_LEN_DEF  = 3;
    localparam int CNT_W_DEF       = 12;
    localparam logic EDGE_FALL = 1'b0;
    localparam logic EDGE_RISE = 1'b1;
endpackage

// File: rtl/input_conditioner_if.sv
// input_conditioner_if: pin input and conditioned edge/interval outputs of the BEP front end
// Signals:
//   raw_in         asynchronous pin
//   digital_out    synchronised, filtered level
//   edge_strobe    one-cycle pulse when digital_out changes
//   edge_rising    direction of that edge (EDGE_RISE / EDGE_FALL)
//   interval       cycles since the previous accepted edge, held between edges
//   interval_valid pulse with edge_strobe except on the first edge after reset
//   interval_ovf   interval saturated at all-ones
// Modports: master = conditioner side, slave = consumer side (decoder and pin driver).
interface input_conditioner_if
    import bep_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             raw_in;
    logic             digital_out;
    logic             edge_strobe;
    logic             edge_rising;
    logic [CNT_W-1:0] interval;
    logic             interval_valid;
    logic             interval_ovf;
    modport master (
        input  raw_in,
        output digital_out, edge_strobe, edge_rising, interval, interval_valid, interval_ovf
    );
    modport slave (
        output raw_in,
        input  digital_out, edge_strobe, edge_rising, interval, interval_valid, interval_ovf
    );
endinterface

// File: rtl/bit_synchronizer.sv
// bit_synchronizer: plain flop chain for bringing an asynchronous bit into the clock domain
// Ports: clock, reset (sync, active-high, clears the chain), d (async in), q (synchronised out).
// STAGES must be at least 2; no logic sits between the flops.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge clock) begin
        if (reset) chain <= '0;
        else       chain <= {chain[STAGES-2:0], d};
    end
    assign q = chain[STAGES-1];
endmodule

// File: rtl/input_conditioner.sv
// input_conditioner: synchronise, deglitch and time the BEP input pin
// Ports: clock, reset (sync, active-high), bus (input_conditioner_if.master: raw_in in,
//   digital_out / edge_strobe / edge_rising / interval / interval_valid / interval_ovf out).
// Optional: define INPUT_CONDITIONER_INVERT_EN to invert raw_in ahead of the synchroniser.
// A level change reaches digital_out SYNC_STAGES+FILTER_LEN+1 clocks after the pin settles.
module input_conditioner
    import bep_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = FILTER_LEN_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input logic                 clock,
    input logic                 reset,
    input_conditioner_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    logic                  pin;
    logic                  sync_q;
    logic [FILTER_LEN-1:0] win;
    logic                  level;
    logic                  first;
    logic [CNT_W-1:0]      cnt;
    logic                  all_hi;
    logic                  all_lo;
    logic                  accept;
    logic                  sat;
    logic [CNT_W-1:0]      cnt_next;
`ifdef INPUT_CONDITIONER_INVERT_EN
    assign pin = ~bus.raw_in;
`else
    assign pin = bus.raw_in;
`endif
    bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (pin),
        .q     (sync_q)
    );
    // A change is accepted only when the whole window agrees on the opposite level.
    always_comb begin
        all_hi   = &win;
        all_lo   = ~|win;
        accept   = (all_hi & ~level) | (all_lo & level);
        sat      = (cnt == CNT_MAX);
        cnt_next = accept ? CNT_W'(1) : (sat ? cnt : cnt + CNT_W'(1));
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            win                <= '0;
            level              <= 1'b0;
            first              <= 1'b1;
            cnt                <= '0;
            bus.edge_strobe    <= 1'b0;
            bus.edge_rising    <= 1'b0;
            bus.interval       <= '0;
            bus.interval_valid <= 1'b0;
            bus.interval_ovf   <= 1'b0;
        end else begin
            // Shift-left form keeps FILTER_LEN == 1 legal.
            win                <= (win << 1) | FILTER_LEN'(sync_q);
            level              <= accept ? ~level : level;
            first              <= accept ? 1'b0 : first;
            cnt                <= cnt_next;
            bus.edge_strobe    <= accept;
            bus.edge_rising    <= accept ? (all_hi ? EDGE_RISE : EDGE_FALL) : bus.edge_rising;
            bus.interval       <= accept ? cnt : bus.interval;
            bus.interval_valid <= accept & ~first;
            bus.interval_ovf   <= accept ? sat : bus.interval_ovf;
        end
    end
    assign bus.digital_out = level;
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: scoreboard bench for input_conditioner
// Stimulus tasks push the edge each pin change should produce; a monitor pops and compares.
module tb_input_conditioner;
    import bep_pkg::*;
    localparam int SYNC = SYNC_STAGES_DEF;
    localparam int FL   = FILTER_LEN_DEF;
    localparam int W    = CNT_W_DEF;
    localparam int LAT  = SYNC + FL + 1;
    localparam int MAXC = (1 << W) - 1;
`ifdef INPUT_CONDITIONER_INVERT_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif
    typedef struct {
        int cyc;
        bit rise;
        bit valid;
        int intv;
        bit ovf;
    } ev_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    ev_t  q[$];
    ev_t  ev;
    int   n_cmp = 0;
    int   n_err = 0;
    int   last_cyc = 0;
    bit   first = 1'b1;
    bit   mdl = 1'b0;
    bit   pin_l = 1'b0;
    logic prev_dout = 1'b0;
    input_conditioner_if #(.CNT_W(W)) bus ();
    input_conditioner #(.SYNC_STAGES(SYNC), .FILTER_LEN(FL), .CNT_W(W)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic set_pin(input bit l);
        pin_l      = l;
        bus.raw_in = l ^ INV;
    endtask
    // Pin change made now (just after edge cyc) shows on digital_out after edge cyc+LAT.
    task automatic push_edge(input bit rise);
        int e;
        int d;
        e = cyc + LAT;
        d = e - last_cyc;
        q.push_back('{cyc: e, rise: rise, valid: !first, intv: (d > MAXC) ? MAXC : d, ovf: (d >= MAXC)});
        last_cyc = e;
        first    = 1'b0;
        mdl      = rise;
    endtask
    task automatic hold_pin(input bit l, input int n);
        set_pin(l);
        if (l != mdl && n >= FL) push_edge(l);
        tick(n);
    endtask
    // Counter is 0 after the last reset edge r, so an edge at e reports e-(r+1).
    task automatic do_reset(input int n);
        rst = 1'b1;
        q.delete();
        tick(n);
        chk("rst_dout",     32'(bus.digital_out),    0);
        chk("rst_strobe",   32'(bus.edge_strobe),    0);
        chk("rst_rising",   32'(bus.edge_rising),    0);
        chk("rst_interval", 32'(bus.interval),       0);
        chk("rst_valid",    32'(bus.interval_valid), 0);
        chk("rst_ovf",      32'(bus.interval_ovf),   0);
        rst      = 1'b0;
        first    = 1'b1;
        mdl      = 1'b0;
        last_cyc = cyc + 1;
        if (pin_l) push_edge(1'b1);
    endtask
    always begin
        @(posedge clk);
        #2;
        if (!rst) begin
            if (bus.edge_strobe) begin
                if (q.size() == 0) chk("unexpected_edge", 1, 0);
                else begin
                    ev = q.pop_front();
                    chk("edge_cycle",  32'(cyc),                ev.cyc);
                    chk("edge_rising", 32'(bus.edge_rising),    32'(ev.rise));
                    chk("edge_dout",   32'(bus.digital_out),    32'(ev.rise));
                    chk("edge_valid",  32'(bus.interval_valid), 32'(ev.valid));
                    chk("edge_intv",   32'(bus.interval),       ev.intv);
                    chk("edge_ovf",    32'(bus.interval_ovf),   32'(ev.ovf));
                end
            end
            if (bus.digital_out !== prev_dout) chk("dout_change_has_strobe", 32'(bus.edge_strobe), 1);
            if (bus.interval_valid && !bus.edge_strobe) chk("valid_without_strobe", 1, 0);
        end
        prev_dout = bus.digital_out;
    end
    initial begin
        set_pin(1'b0);
        do_reset(3);
        // Step to 1 at cycle 10 -> first edge at cycle 16, no interval_valid.
        tick(10 - cyc);
        hold_pin(1'b1, 40);
        for (int i = 0; i < 6; i++) hold_pin(i[0], 40);
        hold_pin(1'b0, 40);
        // 2-cycle glitch is rejected; 3-cycle pulse is accepted.
        hold_pin(1'b1, 2);
        hold_pin(1'b0, 30);
        hold_pin(1'b1, 3);
        hold_pin(1'b0, 30);
        // Long quiet period saturates the interval.
        hold_pin(1'b1, 5000);
        hold_pin(1'b0, 40);
        // Reset two cycles into a new level discards it; the level then re-emerges as a first edge.
        set_pin(1'b1);
        tick(2);
        do_reset(2);
        tick(40);
        hold_pin(1'b0, 40);
        // Idle pin from reset gives no edge; then back-to-back edges at minimum spacing.
        do_reset(2);
        tick(60);
        hold_pin(1'b1, 3);
        hold_pin(1'b0, 3);
        hold_pin(1'b1, 3);
        hold_pin(1'b0, 40);
        tick(20);
        chk("queue_drained", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
